// File: rtl/weightbuffer_pkg.sv
// weightbuffer_pkg: shared types for the weight buffer loader
package weightbuffer_pkg;

    localparam int WB_N_I = 512;
    localparam int WB_K   = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FLUSH,
        S_COMMIT,
        S_HOLD
    } loader_state_e;

    typedef logic [0:WB_K-1][0:WB_K-1][0:WB_N_I-1][1:0] kernel_t;

endpackage

// File: rtl/wbl_beat_counter.sv
// wbl_beat_counter: beat counter with clear, increment and last-beat flag
module wbl_beat_counter #(
    parameter int NB = 36,
    parameter int W  = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = cnt == W'(NB - 1);

    // clear wins over increment so a new command always restarts at beat 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)    cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/weightbuffer_loader.sv
// weightbuffer_loader: stages one ternary kernel and commits it to one OCU buffer block
module weightbuffer_loader
    import weightbuffer_pkg::*;
#(
    parameter int N_I  = 512,
    parameter int K    = 3,
    parameter int N_O  = 96,
    parameter int IN_T = 128
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cmd_valid_i,
    output logic                                cmd_ready_o,
    input  logic                                cmd_flush_i,
    input  logic [$clog2(N_O)-1:0]              cmd_ocu_i,
    input  logic                                data_valid_i,
    output logic                                data_ready_o,
    input  logic [IN_T*2-1:0]                   data_i,
    output logic [0:K-1][0:K-1][0:N_I-1][1:0]   wb_data_o,
    output logic [N_O-1:0]                      wb_save_enable_o,
    output logic [N_O-1:0]                      wb_flush_o,
    output logic                                done_o,
    output logic                                err_o
);

    localparam int BPP   = N_I / IN_T;
    localparam int NB    = K * K * BPP;
    localparam int CNT_W = $clog2(NB);
    localparam int KW    = $clog2(K);
    localparam int CW    = $clog2(N_I);
    localparam int OW    = $clog2(N_O);

    loader_state_e          state;
    logic [OW-1:0]          tgt;
    logic                   tgt_bad;
    logic [CNT_W-1:0]       cnt;
    logic                   last;
    logic                   cmd_hs;
    logic                   data_hs;
    logic                   cmd_ok;
    logic [N_O-1:0]         cmd_oh;
    logic [N_O-1:0]         tgt_oh;
    logic [KW-1:0]          k0;
    logic [KW-1:0]          k1;
    logic [CW-1:0]          ch0;
    logic [0:IN_T-1][1:0]   beat;

    assign cmd_hs  = cmd_valid_i & cmd_ready_o;
    assign data_hs = data_valid_i & data_ready_o;
    assign cmd_ok  = {1'b0, cmd_ocu_i} < (OW+1)'(N_O);
    assign cmd_oh  = cmd_ok ? N_O'(1) << cmd_ocu_i : '0;
    assign tgt_oh  = tgt_bad ? '0 : N_O'(1) << tgt;

    // lane 0 of the beat is the lowest channel of its slice
    for (genvar i = 0; i < IN_T; i++) begin : g_lane
        assign beat[i] = data_i[2*i +: 2];
    end

    wbl_beat_counter #(.NB(NB), .W(CNT_W)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (cmd_hs),
        .inc   (data_hs),
        .cnt   (cnt),
        .last  (last)
    );

    // map the beat index onto kernel position (k0,k1) and channel slice base
    always_comb begin
        k0  = KW'(cnt / CNT_W'(BPP * K));
        k1  = KW'((cnt / CNT_W'(BPP)) % CNT_W'(K));
        ch0 = CW'(cnt % CNT_W'(BPP)) * CW'(IN_T);
    end

    // staging register only changes on an accepted beat, so it is frozen in COMMIT/HOLD
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        wb_data_o <= '0;
        else if (data_hs) wb_data_o[k0][k1][ch0 +: IN_T] <= beat;
    end

    // control FSM; every output is a flop so the latch enables are glitch-free
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= S_IDLE;
            tgt              <= '0;
            tgt_bad          <= 1'b0;
            cmd_ready_o      <= 1'b1;
            data_ready_o     <= 1'b0;
            wb_save_enable_o <= '0;
            wb_flush_o       <= '0;
            done_o           <= 1'b0;
            err_o            <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (cmd_hs) begin
                    tgt         <= cmd_ocu_i;
                    tgt_bad     <= !cmd_ok;
                    cmd_ready_o <= 1'b0;
                    if (cmd_flush_i) begin
                        state      <= S_FLUSH;
                        wb_flush_o <= cmd_oh;
                    end else begin
                        state        <= S_FILL;
                        data_ready_o <= 1'b1;
                    end
                end
                S_FILL: if (data_hs && last) begin
                    state            <= S_COMMIT;
                    data_ready_o     <= 1'b0;
                    wb_save_enable_o <= tgt_oh;
                end
                S_COMMIT: begin
                    state            <= S_HOLD;
                    wb_save_enable_o <= '0;
                    done_o           <= 1'b1;
                    err_o            <= tgt_bad;
                end
                S_FLUSH: begin
                    state      <= S_HOLD;
                    wb_flush_o <= '0;
                    done_o     <= 1'b1;
                    err_o      <= tgt_bad;
                end
                S_HOLD: begin
                    state       <= S_IDLE;
                    done_o      <= 1'b0;
                    err_o       <= 1'b0;
                    cmd_ready_o <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weightbuffer_loader.sv
// tb_weightbuffer_loader: randomized bench with a schedule-based reference model
module tb_weightbuffer_loader;
    import weightbuffer_pkg::*;

    localparam int N_I  = 512;
    localparam int K    = 3;
    localparam int N_O  = 5;
    localparam int IN_T = 128;
    localparam int BPP  = N_I / IN_T;
    localparam int NB   = K * K * BPP;
    localparam int NEVER = 32'h7fff_ffff;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic                 cmd_flush = 1'b0;
    logic [2:0]           cmd_ocu = '0;
    logic                 data_valid = 1'b0;
    logic                 data_ready;
    logic [IN_T*2-1:0]    data = '0;
    kernel_t              wb_data;
    logic [N_O-1:0]       wb_save;
    logic [N_O-1:0]       wb_flush;
    logic                 done;
    logic                 err;

    weightbuffer_loader #(.N_I(N_I), .K(K), .N_O(N_O), .IN_T(IN_T)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_flush_i      (cmd_flush),
        .cmd_ocu_i        (cmd_ocu),
        .data_valid_i     (data_valid),
        .data_ready_o     (data_ready),
        .data_i           (data),
        .wb_data_o        (wb_data),
        .wb_save_enable_o (wb_save),
        .wb_flush_o       (wb_flush),
        .done_o           (done),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference model: a kernel image plus the cycle numbers at which each event is due
    kernel_t m_k;
    int m_ready_at, m_save_at, m_flush_at, m_done_at, m_beats, m_tgt;
    bit m_fill, m_bad;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = '0;
            m_ready_at = 0;
            m_save_at = -1;
            m_flush_at = -1;
            m_done_at = -1;
            m_beats = 0;
            m_fill = 1'b0;
            m_bad = 1'b0;
            m_tgt = 0;
        end else begin
            if (cmd_valid && cyc >= m_ready_at) begin
                m_tgt = int'(cmd_ocu);
                m_bad = m_tgt >= N_O;
                if (cmd_flush) begin
                    m_flush_at = cyc + 1;
                    m_done_at = cyc + 2;
                    m_ready_at = cyc + 3;
                end else begin
                    m_fill = 1'b1;
                    m_beats = 0;
                    m_ready_at = NEVER;
                end
            end else if (data_valid && m_fill) begin
                for (int l = 0; l < IN_T; l++)
                    m_k[(m_beats / BPP) / K][(m_beats / BPP) % K][(m_beats % BPP) * IN_T + l] = data[2*l +: 2];
                m_beats++;
                if (m_beats == NB) begin
                    m_fill = 1'b0;
                    m_save_at = cyc + 1;
                    m_done_at = cyc + 2;
                    m_ready_at = cyc + 3;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_kernel(input string name, input kernel_t exp);
        bit bad;
        bad = 1'b0;
        n_cmp++;
        if (wb_data !== exp) begin
            n_fail++;
            for (int p = 0; p < K*K && !bad; p++)
                for (int c = 0; c < N_I && !bad; c++)
                    if (wb_data[p/K][p%K][c] !== exp[p/K][p%K][c]) begin
                        bad = 1'b1;
                        $display("FAIL %s @cyc %0d: pos (%0d,%0d) ch %0d got %0d expected %0d",
                                 name, cyc, p/K, p%K, c, wb_data[p/K][p%K][c], exp[p/K][p%K][c]);
                    end
        end
    endtask

    // observations of the DUT used by the hand-computed pins
    int save_cnt, flush_cnt, err_cnt, save_cyc, flush_cyc, done_cyc, err_cyc;
    logic [N_O-1:0] save_val, flush_val;

    task automatic clear_obs();
        save_cnt = 0; flush_cnt = 0; err_cnt = 0;
        save_cyc = -1; flush_cyc = -1; done_cyc = -1; err_cyc = -1;
        save_val = '0; flush_val = '0;
    endtask

    // per-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(cyc >= m_ready_at));
            chk("data_ready", 32'(data_ready), 32'(m_fill));
            chk("save_enable", 32'(wb_save), (cyc == m_save_at && !m_bad) ? 32'(1) << m_tgt : 32'd0);
            chk("flush", 32'(wb_flush), (cyc == m_flush_at && !m_bad) ? 32'(1) << m_tgt : 32'd0);
            chk("done", 32'(done), 32'(cyc == m_done_at));
            chk("err", 32'(err), 32'(cyc == m_done_at && m_bad));
            chk_kernel("wb_data", m_k);
            if (wb_save != '0) begin save_cnt++; save_val = wb_save; save_cyc = cyc; end
            if (wb_flush != '0) begin flush_cnt++; flush_val = wb_flush; flush_cyc = cyc; end
            if (done) done_cyc = cyc;
            if (err) begin err_cnt++; err_cyc = cyc; end
        end
    end

    int acc_cyc, last_cyc;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input bit fl, input int ocu);
        bit hs;
        int k;
        cmd_valid = 1'b1;
        cmd_flush = fl;
        cmd_ocu = 3'(ocu);
        k = 0;
        do begin
            hs = cmd_ready;
            step(1);
            k++;
        end while (!hs && k < 200);
        if (!hs) chk("cmd_handshake_timeout", 32'd0, 32'd1);
        acc_cyc = cyc - 1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beats(input int n, input bit pat, input bit gap, input bit hold);
        bit hs;
        int k;
        for (int b = 0; b < n; b++) begin
            for (int l = 0; l < IN_T; l++)
                data[2*l +: 2] = pat ? 2'(b % 3) : 2'($urandom_range(0, 3));
            data_valid = 1'b1;
            k = 0;
            do begin
                hs = data_ready;
                step(1);
                k++;
            end while (!hs && k < 200);
            if (!hs) chk("beat_handshake_timeout", 32'd0, 32'd1);
            last_cyc = cyc - 1;
            if (gap) begin
                data_valid = 1'b0;
                step(1);
            end
        end
        if (hold) data = {8{$urandom()}};
        else data_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_obs();
        step(3);
        #3 rst = 1'b0;
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_data_ready", 32'(data_ready), 32'd0);
        chk("reset_save", 32'(wb_save), 32'd0);
        chk("reset_flush", 32'(wb_flush), 32'd0);
        chk("reset_done_err", 32'({done, err}), 32'd0);
        chk_kernel("reset_wb_data", '0);
        step(1);
        chk_en = 1'b1;

        clear_obs();
        do_cmd(1'b0, 2);
        chk("t1_accept_data_ready", 32'(data_ready), 32'd1);
        send_beats(NB, 1'b1, 1'b0, 1'b0);
        step(4);
        chk("t1_save_count", 32'(save_cnt), 32'd1);
        chk("t1_save_value", 32'(save_val), 32'b00100);
        chk("t1_save_delay", 32'(save_cyc - last_cyc), 32'd1);
        chk("t1_done_delay", 32'(done_cyc - save_cyc), 32'd1);
        chk("t1_pos12_ch300", 32'(wb_data[1][2][300]), 32'd1);
        chk("t1_pos00_ch0", 32'(wb_data[0][0][0]), 32'd0);
        chk("t1_pos22_ch511", 32'(wb_data[2][2][511]), 32'd2);

        clear_obs();
        do_cmd(1'b0, 1);
        send_beats(NB, 1'b1, 1'b1, 1'b0);
        step(4);
        chk("t2_save_count", 32'(save_cnt), 32'd1);
        chk("t2_save_value", 32'(save_val), 32'b00010);
        chk("t2_pos12_ch300", 32'(wb_data[1][2][300]), 32'd1);

        clear_obs();
        do_cmd(1'b1, 0);
        step(4);
        chk("t3_flush_value", 32'(flush_val), 32'b00001);
        chk("t3_flush_count", 32'(flush_cnt), 32'd1);
        chk("t3_flush_delay", 32'(flush_cyc - acc_cyc), 32'd1);
        chk("t3_done_delay", 32'(done_cyc - acc_cyc), 32'd2);
        chk("t3_no_save", 32'(save_cnt), 32'd0);
        chk("t3_pos12_ch300", 32'(wb_data[1][2][300]), 32'd1);

        clear_obs();
        do_cmd(1'b0, 5);
        send_beats(NB, 1'b0, 1'b0, 1'b0);
        step(4);
        chk("t4_no_save", 32'(save_cnt), 32'd0);
        chk("t4_no_flush", 32'(flush_cnt), 32'd0);
        chk("t4_err_count", 32'(err_cnt), 32'd1);
        chk("t4_err_with_done", 32'(err_cyc - done_cyc), 32'd0);

        clear_obs();
        do_cmd(1'b0, 1);
        send_beats(20, 1'b0, 1'b0, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_save", 32'(wb_save), 32'd0);
        chk("t5_rst_data_ready", 32'(data_ready), 32'd0);
        chk("t5_rst_done_err", 32'({done, err}), 32'd0);
        chk_kernel("t5_rst_wb_data", '0);
        data_valid = 1'b0;
        step(2);
        #3 rst = 1'b0;
        step(3);
        chk("t5_no_save_after_reset", 32'(save_cnt), 32'd0);
        do_cmd(1'b0, 3);
        send_beats(NB, 1'b0, 1'b0, 1'b0);
        step(4);
        chk("t5_save_count", 32'(save_cnt), 32'd1);
        chk("t5_save_value", 32'(save_val), 32'b01000);

        clear_obs();
        do_cmd(1'b0, 4);
        send_beats(NB, 1'b0, 1'b0, 1'b1);
        do_cmd(1'b1, 1);
        data_valid = 1'b0;
        chk("t6_next_accept", 32'(acc_cyc - last_cyc), 32'd3);
        step(4);
        chk("t6_save_value", 32'(save_val), 32'b10000);
        chk("t6_flush_value", 32'(flush_val), 32'b00010);

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_cmd(1'b1, $urandom_range(0, 6));
            end else begin
                do_cmd(1'b0, $urandom_range(0, 6));
                send_beats(NB, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            step($urandom_range(0, 3));
        end
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
